// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box, rcon lookup and UNROLL legality check.
// Pure combinational helpers with no latency and no flow control of their own.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int BLOCK_W       = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_OUT
  } fsm_t;

  // Byte 0x00 sits in the most significant slot, so a lookup indexes with ~b.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit legal_unroll(input int u);
    return (u == 1) || (u == 2) || (u == 5) || (u == 10);
  endfunction

endpackage

// File: rtl/aes128_enc_unrolled_if.sv
// Job-in / ciphertext-out valid-ready bundle of the unrolled AES-128 core.
// Carries no logic: latency and backpressure are defined by the core.
interface aes128_enc_unrolled_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_key;
  block_t in_pt;
  logic   out_valid;
  logic   out_ready;
  block_t ct_data;

  modport master (
    output in_valid, in_key, in_pt, out_ready,
    input  in_ready, out_valid, ct_data
  );

  modport slave (
    input  in_valid, in_key, in_pt, out_ready,
    output in_ready, out_valid, ct_data
  );

endinterface

// File: rtl/aes_key_expand_128.sv
// AES-128 next-round-key generator from the previous round key and rcon.
// Combinational, zero latency, no flow control.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  block_t     rk_in,
  input  logic [7:0] rcon,
  output block_t     rk_out
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  // RotWord then SubWord on the last column, rcon folded into the top byte.
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round.sv
// One AES round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
// Combinational, zero latency, no flow control.
module aes_round
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t rk,
  input  logic   is_final,
  output block_t state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte k is row k%4, column k/4 of the column-major state.
  for (genvar k = 0; k < 16; k++) begin : g_sub
    assign sb[k] = sbox(state_in[127-8*k -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[c*4+r] = sb[((c+r)%4)*4+r];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[c*4+0];
    assign a1 = sr[c*4+1];
    assign a2 = sr[c*4+2];
    assign a3 = sr[c*4+3];

    assign mc[c*4+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[c*4+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[c*4+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[c*4+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar k = 0; k < 16; k++) begin : g_ark
    assign state_out[127-8*k -: 8] = (is_final ? sr[k] : mc[k]) ^ rk[127-8*k -: 8];
  end

endmodule

// File: rtl/aes_round_stage.sv
// One unrolled pipeline slice: expands the round key and applies one round with it.
// Combinational, zero latency, no flow control.
module aes_round_stage
  import aes_pkg::*;
(
  input  block_t     state_in,
  input  block_t     rk_in,
  input  logic [7:0] rcon,
  input  logic       is_final,
  output block_t     state_out,
  output block_t     rk_out
);

  aes_key_expand_128 u_kexp (
    .rk_in  (rk_in),
    .rcon   (rcon),
    .rk_out (rk_out)
  );

  aes_round u_round (
    .state_in  (state_in),
    .rk        (rk_out),
    .is_final  (is_final),
    .state_out (state_out)
  );

endmodule

// File: rtl/aes128_enc_unrolled.sv
// AES-128 encryptor computing UNROLL rounds per step; 10/UNROLL steps after accept.
// Registered ciphertext holds under out_ready=0; the final step stalls until the slot frees.
module aes128_enc_unrolled
  import aes_pkg::*;
#(
  parameter int UNROLL      = 1,
  parameter bit KEEP_OUTPUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes128_enc_unrolled_if.slave bus,
  input  logic                 step_en,
  input  logic                 abort,
  output logic                 busy,
  output block_t               state,
  output logic [3:0]           round
);

  if (!legal_unroll(UNROLL)) begin : g_bad_unroll
    $fatal(1, "aes128_enc_unrolled: UNROLL=%0d is not one of 1, 2, 5, 10", UNROLL);
  end

  localparam logic [3:0] LAST_BASE = 4'(AES128_ROUNDS - UNROLL);
  localparam logic [3:0] ROUND_INC = 4'(UNROLL);

  fsm_t       fsm_q, fsm_d;
  block_t     state_q, rk_q, ct_q;
  logic [3:0] round_q;
  logic       out_valid_q;

  logic accept, slot_free, last_step, step_go, load_out;

  block_t st_chain [UNROLL+1];
  block_t rk_chain [UNROLL+1];

  assign st_chain[0] = state_q;
  assign rk_chain[0] = rk_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_stage
    logic [3:0] idx;
    assign idx = round_q + 4'(i + 1);

    aes_round_stage u_stage (
      .state_in  (st_chain[i]),
      .rk_in     (rk_chain[i]),
      .rcon      (rcon_of(idx)),
      .is_final  (idx == 4'(AES128_ROUNDS)),
      .state_out (st_chain[i+1]),
      .rk_out    (rk_chain[i+1])
    );
  end

  assign busy         = (fsm_q != ST_IDLE);
  assign bus.in_ready = rst_n && (fsm_q == ST_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign slot_free    = !out_valid_q || bus.out_ready;
  assign last_step    = (round_q == LAST_BASE);
  assign step_go      = busy && step_en && !abort && (!last_step || slot_free);
  assign load_out     = step_go && last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) fsm_d = ST_RUN;
      end
      ST_RUN, ST_WAIT_OUT: begin
        if (abort || load_out) begin
          fsm_d = ST_IDLE;
        end else if (step_en && last_step) begin
          // Final step wanted but the previous ciphertext is still unclaimed.
          fsm_d = ST_WAIT_OUT;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
    end else if (accept) begin
      state_q <= bus.in_pt ^ bus.in_key;
      rk_q    <= bus.in_key;
      round_q <= '0;
    end else if (busy && abort) begin
      round_q <= '0;
    end else if (step_go) begin
      state_q <= st_chain[UNROLL];
      rk_q    <= rk_chain[UNROLL];
      round_q <= round_q + ROUND_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ct_q        <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      ct_q        <= st_chain[UNROLL];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      if (!KEEP_OUTPUT) ct_q <= '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ct_data   = ct_q;
  assign state         = state_q;
  assign round         = round_q;

endmodule

// File: tb/tb_aes128_enc_unrolled.sv
// Directed-plus-random bench for the unrolled AES-128 core against a GF(2^8) reference.
module tb_aes128_enc_unrolled;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk, rst_n, step_en, abort, busy;
  logic [127:0] state_o;
  logic [3:0]   round_o;
  int tests, fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes128_enc_unrolled_if bus ();

  aes128_enc_unrolled #(.UNROLL(1), .KEEP_OUTPUT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .step_en(step_en), .abort(abort),
    .busy(busy), .state(state_o), .round(round_o)
  );

  // Sweep instances: UNROLL 2, 5, 10 and UNROLL 1 with KEEP_OUTPUT=0.
  logic sw_valid, sw_ready, sw_step, sw_abort;
  logic [127:0] sw_key, sw_pt;
  logic sw_ov [4];
  logic sw_ir [4];
  logic sw_busy [4];
  logic [127:0] sw_ct [4];
  logic [127:0] sw_state [4];
  logic [3:0] sw_round [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int U = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 10 : 1;
    localparam bit K = (g != 3);
    aes128_enc_unrolled_if sbus ();
    assign sbus.in_valid  = sw_valid;
    assign sbus.in_key    = sw_key;
    assign sbus.in_pt     = sw_pt;
    assign sbus.out_ready = sw_ready;
    assign sw_ov[g] = sbus.out_valid;
    assign sw_ir[g] = sbus.in_ready;
    assign sw_ct[g] = sbus.ct_data;
    aes128_enc_unrolled #(.UNROLL(U), .KEEP_OUTPUT(K)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(sbus), .step_en(sw_step), .abort(sw_abort),
      .busy(sw_busy[g]), .state(sw_state[g]), .round(sw_round[g])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, acc, m;
    logic [31:0] tmp, rkw;
    logic [127:0] res;
    int d;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbt[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[c*4+r] = s[((c+r)%4)*4+r];
      for (int c = 0; c < 4; c++) begin
        rkw = w[4*rnd+c];
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
              d = (j - r + 4) % 4;
              m = (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
              acc = acc ^ gmul(m, t[c*4+j]);
            end
          end else begin
            acc = t[c*4+r];
          end
          s[c*4+r] = acc ^ rkw[31-8*r -: 8];
        end
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic int sweep_lat(input int g);
    return (g == 0) ? 5 : (g == 1) ? 2 : (g == 2) ? 1 : 10;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_main(input logic [127:0] k, input logic [127:0] p);
    bus.in_key = k; bus.in_pt = p; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_key = rnd128(); bus.in_pt = rnd128();
  endtask

  task automatic wait_main_valid(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv, xb;
    logic [127:0] k, p, expv, prev_s, pending, got;
    logic [3:0] prev_r;
    int lat, cnt, s, seen;
    int sw_lat [4];
    logic [127:0] sw_got [4];
    bit stall [17];

    tests = 0; fails = 0;
    rst_n = 1'b0; step_en = 1'b1; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_key = '0; bus.in_pt = '0; bus.out_ready = 1'b0;
    sw_valid = 1'b0; sw_key = '0; sw_pt = '0; sw_ready = 1'b1; sw_step = 1'b1; sw_abort = 1'b0;

    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, xb);
      end
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_ct", bus.ct_data, 128'd0);
    check("rst_state", state_o, 128'd0);
    check("rst_round", 128'(round_o), 128'd0);
    for (int g = 0; g < 4; g++) check($sformatf("rst_sw%0d_ov", g), 128'(sw_ov[g]), 128'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 128'(bus.in_ready), 128'd1);
    for (int g = 0; g < 4; g++) check($sformatf("rel_sw%0d_ir", g), 128'(sw_ir[g]), 128'd1);

    // FIPS-197 C.1 with UNROLL=1
    bus.out_ready = 1'b1;
    start_main(KEY_C1, PT_C1);
    check("c1_state0", state_o, KEY_C1 ^ PT_C1);
    check("c1_round0", 128'(round_o), 128'd0);
    check("c1_busy", 128'(busy), 128'd1);
    check("c1_in_ready", 128'(bus.in_ready), 128'd0);
    wait_main_valid(20, lat);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_ct", bus.ct_data, CT_C1);
    check("c1_round10", 128'(round_o), 128'd10);
    check("c1_busy_done", 128'(busy), 128'd0);
    tick();
    check("c1_ov_clear", 128'(bus.out_valid), 128'd0);
    check("c1_ct_kept", bus.ct_data, CT_C1);

    // Random jobs against the model
    for (int v = 0; v < 4; v++) begin
      k = rnd128(); p = rnd128();
      start_main(k, p);
      wait_main_valid(20, lat);
      check($sformatf("rand%0d_latency", v), 128'(lat), 128'd10);
      check($sformatf("rand%0d_ct", v), bus.ct_data, aes_ref(k, p));
      tick();
    end

    // UNROLL sweep: App.B then one random block
    for (int v = 0; v < 2; v++) begin
      k = (v == 0) ? KEY_B : rnd128();
      p = (v == 0) ? PT_B : rnd128();
      expv = (v == 0) ? CT_B : aes_ref(k, p);
      sw_key = k; sw_pt = p; sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        check($sformatf("sw%0d_v%0d_state0", g, v), sw_state[g], k ^ p);
        check($sformatf("sw%0d_v%0d_busy", g, v), 128'(sw_busy[g]), 128'd1);
        sw_lat[g] = -1; sw_got[g] = '0;
      end
      for (int n = 1; n <= 12; n++) begin
        tick();
        for (int g = 0; g < 4; g++)
          if (sw_ov[g] && sw_lat[g] < 0) begin
            sw_lat[g] = n; sw_got[g] = sw_ct[g];
          end
      end
      for (int g = 0; g < 4; g++) begin
        check($sformatf("sw%0d_v%0d_latency", g, v), 128'(sw_lat[g]), 128'(sweep_lat(g)));
        check($sformatf("sw%0d_v%0d_ct", g, v), sw_got[g], expv);
        check($sformatf("sw%0d_v%0d_round", g, v), 128'(sw_round[g]), 128'd10);
        check($sformatf("sw%0d_v%0d_ov_clear", g, v), 128'(sw_ov[g]), 128'd0);
        check($sformatf("sw%0d_v%0d_ct_after", g, v), sw_ct[g], (g == 3) ? 128'd0 : expv);
      end
    end

    // Backpressure: second job stalls on its final step
    bus.out_ready = 1'b0;
    start_main(KEY_C1, PT_C1);
    wait_main_valid(20, lat);
    check("bp_first_latency", 128'(lat), 128'd10);
    check("bp_in_ready_pending", 128'(bus.in_ready), 128'd1);
    start_main(KEY_B, PT_B);
    repeat (12) tick();
    check("bp_busy_stalled", 128'(busy), 128'd1);
    check("bp_round9", 128'(round_o), 128'd9);
    check("bp_ov_held", 128'(bus.out_valid), 128'd1);
    check("bp_ct_held", bus.ct_data, CT_C1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_second_ov", 128'(bus.out_valid), 128'd1);
    check("bp_second_ct", bus.ct_data, CT_B);
    check("bp_second_busy", 128'(busy), 128'd0);
    check("bp_second_round", 128'(round_o), 128'd10);
    tick();
    check("bp_ov_clear", 128'(bus.out_valid), 128'd0);

    // step_en low on 3 random cycles
    for (int i = 0; i < 17; i++) stall[i] = 1'b0;
    cnt = 0;
    while (cnt < 3) begin
      s = int'($urandom_range(1, 12));
      if (!stall[s]) begin
        stall[s] = 1'b1;
        cnt++;
      end
    end
    start_main(KEY_C1, PT_C1);
    lat = -1; got = '0;
    for (int n = 1; n <= 16; n++) begin
      step_en = !stall[n];
      prev_s = state_o; prev_r = round_o;
      tick();
      if (stall[n]) begin
        check($sformatf("stall_state_c%0d", n), state_o, prev_s);
        check($sformatf("stall_round_c%0d", n), 128'(round_o), 128'(prev_r));
      end
      if (bus.out_valid && lat < 0) begin
        lat = n; got = bus.ct_data;
      end
    end
    step_en = 1'b1;
    check("stall_latency", 128'(lat), 128'd13);
    check("stall_ct", got, CT_C1);

    // Abort at round 4 with a pending ciphertext
    bus.out_ready = 1'b0;
    k = rnd128(); p = rnd128();
    start_main(k, p);
    wait_main_valid(20, lat);
    pending = aes_ref(k, p);
    check("ab_pending_ct", bus.ct_data, pending);
    start_main(KEY_C1, PT_C1);
    repeat (4) tick();
    check("ab_round4", 128'(round_o), 128'd4);
    prev_s = state_o;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 128'(busy), 128'd0);
    check("ab_round0", 128'(round_o), 128'd0);
    check("ab_state_kept", state_o, prev_s);
    check("ab_ov_kept", 128'(bus.out_valid), 128'd1);
    check("ab_ct_kept", bus.ct_data, pending);
    bus.out_ready = 1'b1;
    tick();
    check("ab_ov_popped", 128'(bus.out_valid), 128'd0);
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("ab_no_output", 128'(seen), 128'd0);
    start_main(KEY_B, PT_B);
    wait_main_valid(20, lat);
    check("ab_b_latency", 128'(lat), 128'd10);
    check("ab_b_ct", bus.ct_data, CT_B);

    // Asynchronous reset mid-job, between edges
    bus.out_ready = 1'b0;
    start_main(KEY_C1, PT_C1);
    repeat (6) tick();
    check("ar_round6", 128'(round_o), 128'd6);
    check("ar_ct_before", bus.ct_data, CT_B);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 128'(busy), 128'd0);
    check("ar_ov", 128'(bus.out_valid), 128'd0);
    check("ar_round", 128'(round_o), 128'd0);
    check("ar_state", state_o, 128'd0);
    check("ar_ct", bus.ct_data, 128'd0);
    check("ar_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    start_main(KEY_C1, PT_C1);
    wait_main_valid(20, lat);
    check("ar_c1_latency", 128'(lat), 128'd10);
    check("ar_c1_ct", bus.ct_data, CT_C1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes128_enc_unrolled.md
Name: aes128_enc_unrolled

Overview:
Parametrised AES-128 encryption core, successor to the iterative one-round-per-cycle core. It evaluates UNROLL rounds per clock and uses valid/ready handshakes on input and output. The output is registered and holds under backpressure, and it supports stall (step_en) and synchronous abort. It sits between the block-cipher mode controllers and the lockstep checker, and exposes its internal state and round count for dual-core comparison.

Parameters:
UNROLL, 1, rounds computed per cycle; legal values 1, 2, 5, 10; any other value is a fatal elaboration error.
KEEP_OUTPUT, 1, 1 = ct_data holds its last value after acceptance; 0 = ct_data is driven to zero when out_valid is low.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low (sync release handled upstream)
in_valid  in  1  job request
in_ready  out  1  core can accept a job
in_key  in  128  cipher key, big-endian bytes, AES column-major state
in_pt  in  128  plaintext, same layout
step_en  in  1  0 = freeze the compute datapath this cycle
abort  in  1  synchronous drop of the in-flight job
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
ct_data  out  128  ciphertext
busy  out  1  job in flight
state  out  128  internal state register (lockstep)
round  out  4  last completed round, 0..10

Behaviour:
- Reset (rst_n=0, asynchronous) forces: busy=0, in_ready=0 while asserted, out_valid=0, ct_data=0, state=0, round=0. The round-key register is also 0.
- in_ready = rst_n_released && !busy. It is independent of out_valid, so a new job may start while the previous ciphertext waits.
- Accept when in_valid && in_ready. On that edge: state <= in_pt ^ in_key; rk <= in_key; round <= 0; busy <= 1. step_en is ignored on the accept edge.
- Compute step: occurs when busy && step_en && !abort, and (if this is the final step) the output slot is free.
  - The step chains UNROLL stages. Stage i uses rcon(round+1+i) and final=(round+1+i==10).
  - On the step edge: state and rk take the last stage's outputs, and round <= round+UNROLL.
- Steps per job: N = 10/UNROLL. With step_en held high and no backpressure, out_valid rises on edge T+N, where T is the accept edge. UNROLL=1 gives 10 cycles, matching the iterative core.
- Output slot free = !out_valid || out_ready.
  - On the final step: ct_data <= final state; out_valid <= 1; busy <= 0.
  - round holds at 10 until the next accept.
  - If the slot is not free, the final step stalls: state, rk and round hold, and busy stays 1.
- out_valid clears on out_valid && out_ready unless a new final step loads in the same cycle, in which case it stays 1 with the new data.
- KEEP_OUTPUT=0: ct_data is zeroed on the clear edge.
- step_en=0 freezes state, rk and round. Handshakes still operate.
- abort (busy only): busy <= 0; round <= 0; state is left unchanged. out_valid and ct_data are unaffected. abort while idle is a no-op. abort has priority over a same-cycle step. abort and accept cannot coincide, because accept requires !busy.
- in_key and in_pt are sampled only on the accept edge, so later changes to them are ignored.
- Arithmetic: round is 4 bits and never exceeds 10. rcon is 0x00 for indices outside 1..10; those indices are unreachable.
- X-free: every output has a defined reset value. There are no latches.

Decomposition:
- Shared package aes_pkg:
  - rcon lookup function for indices 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - AES128_ROUNDS=10 and BLOCK_W=128 constants.
  - Legal-UNROLL check function.
- Sub-module aes_round_stage: one existing aes_key_expand_128 feeding one existing aes_round.
  - Inputs: state_in, rk_in, rcon, final.
  - Outputs: state_out, rk_out.
  - The core instantiates UNROLL copies in a generate chain.
- The core holds the handshake FSM: IDLE, RUN, WAIT_OUT.
  - WAIT_OUT is the final-step stall. It is reported as busy=1.

Test Plan:
- FIPS-197 C.1, UNROLL=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> ct_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+10, round=10.
- FIPS-197 App.B, with UNROLL swept over 2, 5, 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32 at T+5, T+2 and T+1 respectively.
- Backpressure: hold out_ready=0 and start a second job (App.B) while C.1 is pending -> second job stalls at round 9 (UNROLL=1) with busy=1. Raising out_ready then pops 69c4…5a, and 3925…32 appears on the next edge.
- Stall: C.1 with step_en low for 3 random cycles -> out_valid at T+13, same ciphertext, and state frozen during the stalls.
- Abort at round 4, then start App.B -> no out_valid for the aborted job, then 3925…32. A pending ct_data is preserved across the abort.
- Asynchronous reset mid-job (rst_n low between edges at round 6) -> busy, out_valid, round, state and ct_data go to 0 immediately. After release, C.1 completes correctly.
